divisor_secuencial_8bits: RTL and testbench

//   Sequential unsigned 8-bit divider, restoring shift-subtract, one quotient bit/clock.

---
 rtl/divisor_secuencial_8bits_pkg.sv | 15 +
 rtl/restador_8bits_1.sv | 17 +
 rtl/divisor_secuencial_8bits.sv | 105 ++++++++++
 tb/tb_divisor_secuencial_8bits.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_secuencial_8bits_pkg.sv
// Shared constants and state type for the sequential 8-bit restoring divider.
package divisor_secuencial_8bits_pkg;

    localparam int DIV_WIDTH  = 8;
    localparam int DIV_N_ITER = 8;
    localparam int DIV_CNT_W  = 3;

    // Encoding 2'd3 is never entered; the FSM treats it like ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restador_8bits_1.sv
// 8-bit subtractor: D = A - B with unsigned borrow and signed overflow flags.
module restador_8bits_1 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] D,
    output logic       Borrow,
    output logic       Ovf
);

    logic [8:0] w_full;

    assign w_full = {1'b0, A} - {1'b0, B};
    assign D      = w_full[7:0];
    assign Borrow = w_full[8];
    assign Ovf    = (A[7] ^ B[7]) & (A[7] ^ D[7]);

endmodule

// File: rtl/divisor_secuencial_8bits.sv
// Sequential unsigned 8-bit restoring divider, one quotient bit per clock,
// built around a single shared restador_8bits_1 subtractor.
module divisor_secuencial_8bits
    import divisor_secuencial_8bits_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int N_ITER = DIV_N_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(N_ITER - 1);

    div_state_t           r_state;
    div_state_t           w_state_next;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_qsh;
    logic [WIDTH-1:0]     r_bq;
    logic [DIV_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]     w_trial;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_borrow;
    logic                 w_ovf_unused;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_qsh_next;
    logic                 w_last;
    logic                 w_accept;

    // acc[7] is always 0 during RUN, so dropping it in the shift loses nothing.
    assign w_trial = {r_acc[WIDTH-2:0], r_qsh[WIDTH-1]};

    restador_8bits_1 u_rest (
        .A      (w_trial),
        .B      (r_bq),
        .D      (w_diff),
        .Borrow (w_borrow),
        .Ovf    (w_ovf_unused)
    );

    assign w_acc_next = w_borrow ? w_trial : w_diff;
    assign w_qsh_next = {r_qsh[WIDTH-2:0], ~w_borrow};
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_accept   = start && (r_state != ST_RUN);

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_RUN: begin
                busy = 1'b1;
                if (w_last)
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_qsh    <= '0;
            r_bq     <= '0;
            r_cnt    <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc    <= '0;
                r_qsh    <= A;
                r_bq     <= B;
                r_cnt    <= '0;
                div_zero <= (B == '0);
            end else if (r_state == ST_RUN) begin
                r_acc <= w_acc_next;
                r_qsh <= w_qsh_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    Q <= w_qsh_next;
                    R <= w_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_divisor_secuencial_8bits.sv
// Self-checking bench for divisor_secuencial_8bits: vector table, random
// operands against an arithmetic model, and multi-cycle handshake corners.
module tb_divisor_secuencial_8bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] q_out;
    logic [7:0] r_out;
    logic       busy;
    logic       done;
    logic       div_zero;

    int n_checks = 0;
    int n_errors = 0;

    divisor_secuencial_8bits dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .Q        (q_out),
        .R        (r_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_q(input logic [7:0] a, input logic [7:0] b);
        if (b == 0) return 8'hFF;
        return 8'(int'(a) / int'(b));
    endfunction

    function automatic logic [7:0] model_r(input logic [7:0] a, input logic [7:0] b);
        if (b == 0) return a;
        return 8'(int'(a) % int'(b));
    endfunction

    // Pulse start for one cycle, then wait (bounded) for done; lat counts
    // clock edges from the accepting edge (edge 1) to the one raising done.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] a, input logic [7:0] b,
                                input int lat);
        chk({name, " latency"}, lat, 9);
        chk({name, " Q"}, q_out, model_q(a, b));
        chk({name, " R"}, r_out, model_r(a, b));
        chk({name, " div_zero"}, div_zero, (b == 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) begin
                n_errors++;
                $display("FAIL busy_done_overlap: busy=%0d done=%0d", busy, done);
            end
            if (busy && dut.r_acc[7]) begin
                n_errors++;
                $display("FAIL acc7_invariant: acc=%0d expected bit7 0", dut.r_acc);
            end
        end
    end

    initial begin
        int lat;
        logic [7:0] ra, rb;

        vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0};
        vecs[3] = '{a: 8'd255, b: 8'd200, q: 8'd1,   r: 8'd55,  dz: 1'b0};
        vecs[4] = '{a: 8'd200, b: 8'd0,   q: 8'hFF,  r: 8'd200, dz: 1'b1};
        vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
        vecs[6] = '{a: 8'd199, b: 8'd200, q: 8'd0,   r: 8'd199, dz: 1'b0};
        vecs[7] = '{a: 8'd128, b: 8'd128, q: 8'd1,   r: 8'd0,   dz: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        #23;
        chk("reset Q", q_out, 0);
        chk("reset R", r_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div_zero", div_zero, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d latency", i), lat, 9);
            chk($sformatf("vec%0d Q", i), q_out, vecs[i].q);
            chk($sformatf("vec%0d R", i), r_out, vecs[i].r);
            chk($sformatf("vec%0d div_zero", i), div_zero, vecs[i].dz);
            tick();
            chk($sformatf("vec%0d idle busy", i), busy, 0);
            chk($sformatf("vec%0d held Q", i), q_out, vecs[i].q);
        end

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            do_op(ra, rb, lat);
            check_result($sformatf("rand%0d a=%0d b=%0d", i, ra, rb), ra, rb, lat);
        end

        // start pulse with new operands during RUN is ignored
        do_op(8'd60, 8'd7, lat);
        a_in  = 8'd100;
        b_in  = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore busy at run1", busy, 1);
        tick();
        tick();
        a_in  = 8'd9;
        b_in  = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 4;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        chk("ignore latency", lat, 9);
        chk("ignore Q", q_out, 14);
        chk("ignore R", r_out, 2);
        tick();
        chk("ignore back to idle", busy, 0);

        // start held through DONE: back-to-back with no idle gap
        a_in  = 8'd100;
        b_in  = 8'd7;
        start = 1'b1;
        tick();
        a_in  = 8'd50;
        b_in  = 8'd6;
        lat = 1;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        chk("b2b first latency", lat, 9);
        chk("b2b first Q", q_out, 14);
        chk("b2b first R", r_out, 2);
        chk("b2b done busy low", busy, 0);
        tick();
        start = 1'b0;
        chk("b2b busy next cycle", busy, 1);
        chk("b2b done dropped", done, 0);
        chk("b2b Q held during run", q_out, 14);
        lat = 1;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        chk("b2b second latency", lat, 9);
        chk("b2b second Q", q_out, 8);
        chk("b2b second R", r_out, 2);
        tick();

        // reset in the middle of RUN aborts without a done pulse
        a_in  = 8'd100;
        b_in  = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort busy before reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort Q", q_out, 0);
        chk("abort R", r_out, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        tick();
        rst_n = 1'b1;
        begin
            int seen_done = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done || busy) seen_done = 1;
            end
            chk("abort no done pulse", seen_done, 0);
        end
        do_op(8'd100, 8'd7, lat);
        check_result("after abort", 8'd100, 8'd7, lat);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
